dmem_responder: RTL and testbench
=================================

# dmem_responder

Word-addressed data-memory responder that serves the core's data-memory request/grant/valid interface from the memory side. It accepts one request per grant, applies programmable grant wait states, and writes with byte enables or reads a register-array memory. It returns read data plus a 7-bit integrity code one cycle after grant, and flags out-of-range accesses with an error response. It sits at the far end of the core's data port in simulation and FPGA top levels, replacing an external RAM model.

## Interface
Parameters:
- DEPTH, 1024: memory size in 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; word aligned.
- GNT_WAIT, 0: number of extra cycles `data_req_i` must be held before `data_gnt_o`; range 0..15.

Ports:
- clk_i  in  1  clock; everything is rising-edge.
- rst_i  in  1  reset, synchronous, active-high.
- data_req_i  in  1  request valid; held until granted.
- data_gnt_o  out  1  request accepted this cycle.
- data_rvalid_o  out  1  response valid; exactly one per grant.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables; bit i covers bits [8i+7:8i].
- data_addr_i  in  32  byte address; bits [1:0] ignored.
- data_wdata_i  in  32  write data, already lane-aligned.
- data_wdata_intg_i  in  7  write-data integrity code.
- data_rdata_o  out  32  read data; 0 for writes and errors.
- data_rdata_intg_o  out  7  integrity code of `data_rdata_o`.
- data_err_o  out  1  error response; qualified by `data_rvalid_o`.

## Operation
- Integrity code: `intg[k]` is the XOR of all `data[j]` where `j mod 7 == k`, for k = 0..6. The same function is used to generate and to check.
- Address decode:
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH, compared in 33-bit unsigned arithmetic so the end bound cannot wrap.
  - Word index = (addr - BASE_ADDR) >> 2, truncated to clog2(DEPTH) bits.
- Grant FSM:
  - IDLE → WAIT when `data_req_i`=1 and GNT_WAIT>0; the wait counter loads GNT_WAIT-1.
  - WAIT: counter decrements each cycle `data_req_i`=1. At 0, `data_gnt_o`=1 and the FSM returns to IDLE.
  - WAIT → IDLE with no grant if `data_req_i` drops (protocol violation); the counter clears.
  - With GNT_WAIT=0, `data_gnt_o` = `data_req_i` combinationally while in IDLE and not in reset.
- On a granted cycle:
  - Write, in range: update only the bytes whose enable is set, at the clock edge. `data_be_i`=0 is legal and leaves memory unchanged.
  - Read, in range: capture `mem[index]` into the response register.
  - Out of range: no memory access; the response carries err=1.
- Response register:
  - Loaded on grant. `data_rvalid_o`=1 on the following cycle only.
  - `data_rdata_o` = read word, or 0 for writes and errors.
  - `data_rdata_intg_o` = intg(`data_rdata_o`).
- Back-to-back: a new grant may occur in the same cycle that the previous response is valid, giving full throughput at GNT_WAIT=0.
- Reset:
  - Forces IDLE, counter 0, and `data_gnt_o`, `data_rvalid_o`, `data_err_o`, `data_rdata_o`, `data_rdata_intg_o` all to 0.
  - A request granted in the reset cycle is discarded and its write is suppressed.
  - Memory contents are not reset.

## Timing
- Grant latency: GNT_WAIT cycles after `data_req_i` first rises, counting the rise cycle as 0.
- Response latency: exactly 1 cycle after grant, registered.
- At most one outstanding response at any time.
- Write visibility: a read granted on the cycle after a write's grant to the same word returns the new data.
- Reset mid-wait: no grant is issued. Counting restarts from GNT_WAIT once reset releases.

## Configuration
- DMEM_INTG_CHECK_EN defined:
  - On a granted in-range write, intg(`data_wdata_i`) is compared with `data_wdata_intg_i`.
  - On mismatch: no bytes are written, and the response has err=1 with rdata 0.
- Macro undefined: `data_wdata_intg_i` is ignored; no write ever errors on integrity. `data_rdata_intg_o` is generated in both builds.

## Structure
- Package `dmem_pkg`:
  - Constants: DATA_W=32, INTG_W=7, BE_W=4.
  - FSM state enum: IDLE, WAIT.
  - Pure function `intg_calc` (32-bit data in, 7-bit code out).
- Sub-module `dmem_intg_gen`: combinational wrapper around `intg_calc`. Instantiated once for read data and, when the macro is defined, once for write data.

## Test plan
- Write word, then read it back: BASE_ADDR=0, GNT_WAIT=0. Write 0xDEADBEEF, be=4'b1111, addr 0x10; then read addr 0x10 → grant in the same cycle; rvalid next cycle with rdata=0xDEADBEEF, err=0, intg equal to the xor-fold model.
- Byte write: after the above, write 0x0000AA00, be=4'b0010, addr 0x10; then read → rdata=0xDEADAAEF.
- Out-of-range read: DEPTH=1024, read addr 0x1000 → rvalid with err=1, rdata=0; memory unchanged.
- Wait states: GNT_WAIT=2, `data_req_i` held from cycle 0 → `data_gnt_o`=1 in cycle 2 only; rvalid in cycle 3. Back-to-back requests → grants in cycles 2 and 5.
- Integrity check (DMEM_INTG_CHECK_EN defined): write 0x12345678 with intg XOR 7'h01 → err=1; a following read returns the old word.
- Reset mid-operation: assert `rst_i` in cycle 1 of a GNT_WAIT=2 request → no grant, rvalid stays 0, all outputs 0 in the cycle after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants, grant FSM state type and the xor-fold integrity function
// used by the data-memory responder.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int INTG_W = 7;
  localparam int BE_W   = 4;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  // Bit k of the code folds every data bit whose index is congruent to k mod 7.
  function automatic logic [INTG_W-1:0] intg_calc(input logic [DATA_W-1:0] data);
    logic [INTG_W-1:0] intg;
    intg = '0;
    for (int j = 0; j < DATA_W; j++) begin
      intg[j % INTG_W] ^= data[j];
    end
    return intg;
  endfunction

endpackage

// File: rtl/dmem_intg_gen.sv
// Combinational 7-bit integrity code generator for one 32-bit data word.
module dmem_intg_gen
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [INTG_W-1:0] intg_o
);

  assign intg_o = intg_calc(data_i);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: grant with programmable wait states, byte-enable writes, registered reads.
// Build option DMEM_INTG_CHECK_EN rejects writes whose integrity code does not match the write data.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned GNT_WAIT  = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  input  logic              data_we_i,
  input  logic [BE_W-1:0]   data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  input  logic [INTG_W-1:0] data_wdata_intg_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic [INTG_W-1:0] data_rdata_intg_o,
  output logic              data_err_o
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [32:0] END_EXT   = BASE_EXT + 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  WAIT_INIT = (GNT_WAIT == 0) ? 4'd0 : 4'(GNT_WAIT - 1);

  // ---------------- grant FSM ----------------
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (data_req_i && (GNT_WAIT != 0)) begin
          state_d = WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      WAIT: begin
        if (!data_req_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Reset masks the grant so a request presented during reset never reaches memory.
  always_comb begin
    gnt = 1'b0;
    case (state_q)
      IDLE:    gnt = data_req_i && (GNT_WAIT == 0);
      WAIT:    gnt = data_req_i && (cnt_q == 4'd0);
      default: gnt = 1'b0;
    endcase
    if (rst_i) begin
      gnt = 1'b0;
    end
  end

  assign data_gnt_o = gnt;

  // ---------------- address decode ----------------
  logic [32:0]   addr_ext;
  logic          in_range;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          unused_addr;

  assign addr_ext    = {1'b0, data_addr_i};
  assign in_range    = (addr_ext >= BASE_EXT) && (addr_ext < END_EXT);
  assign offset      = data_addr_i - BASE_ADDR;
  assign idx         = offset[AW+1:2];
  assign unused_addr = ^offset;

  // ---------------- write integrity ----------------
  logic wintg_ok;

`ifdef DMEM_INTG_CHECK_EN
  logic [INTG_W-1:0] wdata_intg;

  dmem_intg_gen u_wdata_intg (
    .data_i (data_wdata_i),
    .intg_o (wdata_intg)
  );

  assign wintg_ok = (wdata_intg == data_wdata_intg_i);
`else
  logic unused_wintg;

  assign wintg_ok     = 1'b1;
  assign unused_wintg = ^data_wdata_intg_i;
`endif

  // ---------------- memory array ----------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [BE_W-1:0]   byte_we;

  assign byte_we = (gnt && in_range && data_we_i && wintg_ok) ? data_be_i : '0;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < BE_W; b++) begin
      if (byte_we[b]) begin
        mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  // ---------------- response register ----------------
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = gnt;
    err_d    = 1'b0;
    rdata_d  = '0;
    if (gnt) begin
      if (!in_range) begin
        err_d = 1'b1;
      end else if (data_we_i) begin
        err_d = !wintg_ok;
      end else begin
        rdata_d = mem_q[idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  dmem_intg_gen u_rdata_intg (
    .data_i (rdata_q),
    .intg_o (data_rdata_intg_o)
  );

  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: one responder with no wait states and one with two wait states.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, we0, gnt0, rvalid0, err0;
  logic [3:0]  be0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [6:0]  wintg0, rintg0;
  logic        req2, we2, gnt2, rvalid2, err2;
  logic [3:0]  be2;
  logic [31:0] addr2, wdata2, rdata2;
  logic [6:0]  wintg2, rintg2;

  dmem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .GNT_WAIT(0)) u0 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req0), .data_gnt_o(gnt0), .data_rvalid_o(rvalid0),
    .data_we_i(we0), .data_be_i(be0), .data_addr_i(addr0), .data_wdata_i(wdata0),
    .data_wdata_intg_i(wintg0), .data_rdata_o(rdata0), .data_rdata_intg_o(rintg0),
    .data_err_o(err0));

  dmem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .GNT_WAIT(2)) u2 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req2), .data_gnt_o(gnt2), .data_rvalid_o(rvalid2),
    .data_we_i(we2), .data_be_i(be2), .data_addr_i(addr2), .data_wdata_i(wdata2),
    .data_wdata_intg_i(wintg2), .data_rdata_o(rdata2), .data_rdata_intg_o(rintg2),
    .data_err_o(err2));

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  rsp_t exp0_q[$];
  rsp_t exp2_q[$];
  chk_t chk_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  function automatic logic [6:0] tb_intg(input logic [31:0] d);
    logic [6:0] r = '0;
    for (int k = 0; k < 7; k++)
      for (int j = k; j < 32; j += 7)
        r[k] = r[k] ^ d[j];
    return r;
  endfunction

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: the only process that compares and counts.
  rsp_t e;
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      chk_t c;
      c = chk_q.pop_front();
      cmp(c.name, c.act, c.exp);
    end
    if (rvalid0) begin
      if (exp0_q.size() == 0) cmp("u0_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        e = exp0_q.pop_front();
        cmp("u0_rdata", rdata0, e.rdata);
        cmp("u0_err", 32'(err0), 32'(e.err));
        cmp("u0_rintg", 32'(rintg0), 32'(tb_intg(e.rdata)));
      end
    end
    if (rvalid2) begin
      if (exp2_q.size() == 0) cmp("u2_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        e = exp2_q.pop_front();
        cmp("u2_rdata", rdata2, e.rdata);
        cmp("u2_err", 32'(err2), 32'(e.err));
        cmp("u2_rintg", 32'(rintg2), 32'(tb_intg(e.rdata)));
      end
    end
    if (done) begin
      cmp("u0_drained", 32'(exp0_q.size()), 32'd0);
      cmp("u2_drained", 32'(exp2_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // Issue one request, wait for its grant, record grant latency and expected response.
  task automatic op(input int u, input logic we, input logic [3:0] be, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [6:0] wintg,
                    input logic exp_err, input logic [31:0] exp_rdata, input int exp_wait);
    int n = 0;
    if (u == 0) begin req0 = 1; we0 = we; be0 = be; addr0 = addr; wdata0 = wdata; wintg0 = wintg; end
    else        begin req2 = 1; we2 = we; be2 = be; addr2 = addr; wdata2 = wdata; wintg2 = wintg; end
    forever begin
      @(negedge clk);
      if ((u == 0) ? gnt0 : gnt2) begin
        if (u == 0) exp0_q.push_back('{exp_err, exp_rdata});
        else        exp2_q.push_back('{exp_err, exp_rdata});
        chk_q.push_back('{"gnt_latency", 32'(n), 32'(exp_wait)});
        break;
      end
      n++;
      if (n > 20) begin
        chk_q.push_back('{"gnt_timeout", 32'd1, 32'd0});
        break;
      end
    end
    @(posedge clk); #1;
    if (u == 0) req0 = 0; else req2 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    req0 = 0; we0 = 0; be0 = 0; addr0 = 0; wdata0 = 0; wintg0 = 0;
    req2 = 0; we2 = 0; be2 = 0; addr2 = 0; wdata2 = 0; wintg2 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_q.push_back('{"rst_gnt0", 32'(gnt0), 32'd0});
    chk_q.push_back('{"rst_rvalid0", 32'(rvalid0), 32'd0});
    chk_q.push_back('{"rst_err0", 32'(err0), 32'd0});
    chk_q.push_back('{"rst_rdata0", rdata0, 32'd0});
    chk_q.push_back('{"rst_rintg0", 32'(rintg0), 32'd0});
    chk_q.push_back('{"rst_rvalid2", 32'(rvalid2), 32'd0});
    @(posedge clk); #1;
    rst = 0;

    // Zero-wait instance, back-to-back traffic.
    op(0, 1, 4'hF, 32'h10,   32'hDEADBEEF, tb_intg(32'hDEADBEEF), 0, 32'h0, 0);
    op(0, 0, 4'hF, 32'h10,   32'h0,        7'h0,                  0, 32'hDEADBEEF, 0);
    op(0, 1, 4'h2, 32'h10,   32'h0000AA00, tb_intg(32'h0000AA00), 0, 32'h0, 0);
    op(0, 0, 4'hF, 32'h10,   32'h0,        7'h0,                  0, 32'hDEADAAEF, 0);
    op(0, 0, 4'hF, 32'h1000, 32'h0,        7'h0,                  1, 32'h0, 0);
    op(0, 1, 4'hF, 32'h1004, 32'h55555555, tb_intg(32'h55555555), 1, 32'h0, 0);
    op(0, 0, 4'hF, 32'h10,   32'h0,        7'h0,                  0, 32'hDEADAAEF, 0);
    op(0, 1, 4'hF, 32'hFFC,  32'hCAFEF00D, tb_intg(32'hCAFEF00D), 0, 32'h0, 0);
    op(0, 0, 4'hF, 32'hFFC,  32'h0,        7'h0,                  0, 32'hCAFEF00D, 0);
    op(0, 1, 4'h0, 32'h10,   32'hFFFFFFFF, tb_intg(32'hFFFFFFFF), 0, 32'h0, 0);
    op(0, 0, 4'hF, 32'h10,   32'h0,        7'h0,                  0, 32'hDEADAAEF, 0);
`ifdef DMEM_INTG_CHECK_EN
    op(0, 1, 4'hF, 32'h10, 32'h12345678, tb_intg(32'h12345678) ^ 7'h01, 1, 32'h0, 0);
    op(0, 0, 4'hF, 32'h10, 32'h0,        7'h0,                           0, 32'hDEADAAEF, 0);
`else
    op(0, 1, 4'hF, 32'h10, 32'h12345678, tb_intg(32'h12345678) ^ 7'h01, 0, 32'h0, 0);
    op(0, 0, 4'hF, 32'h10, 32'h0,        7'h0,                           0, 32'h12345678, 0);
`endif
    repeat (3) @(posedge clk); #1;

    // Two-wait instance: back-to-back requests, grants two cycles after each rise.
    op(2, 1, 4'hF, 32'h0, 32'h11111111, tb_intg(32'h11111111), 0, 32'h0, 2);
    op(2, 0, 4'hF, 32'h0, 32'h0,        7'h0,                  0, 32'h11111111, 2);
    repeat (3) @(posedge clk); #1;

    // Reset in cycle 1 of a pending write: no grant, no response, write dropped.
    req2 = 1; we2 = 1; be2 = 4'hF; addr2 = 32'h0; wdata2 = 32'h22222222;
    wintg2 = tb_intg(32'h22222222);
    @(negedge clk);
    chk_q.push_back('{"rstmid_gnt_c0", 32'(gnt2), 32'd0});
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk_q.push_back('{"rstmid_gnt_c1", 32'(gnt2), 32'd0});
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk_q.push_back('{"rstmid_gnt_after", 32'(gnt2), 32'd0});
    chk_q.push_back('{"rstmid_rvalid", 32'(rvalid2), 32'd0});
    chk_q.push_back('{"rstmid_err", 32'(err2), 32'd0});
    chk_q.push_back('{"rstmid_rdata", rdata2, 32'd0});
    chk_q.push_back('{"rstmid_rintg", 32'(rintg2), 32'd0});
    @(posedge clk); #1;
    req2 = 0;
    @(posedge clk); #1;
    op(2, 0, 4'hF, 32'h0, 32'h0, 7'h0, 0, 32'h11111111, 2);

    repeat (3) @(posedge clk);
    done = 1'b1;
  end

endmodule
